// File: rtl/rng_roll_controller.sv
// Roll sequencer for the random-number display: free-running LFSR, decelerating
// display updates, final value selection and a one-cycle capture strobe.
module rng_roll_controller #(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int unsigned INIT_PERIOD  = 1_000_000,
    parameter int unsigned PERIOD_INC   = 250_000,
    parameter int unsigned NUM_STEPS    = 16,
    parameter bit          AVOID_REPEAT = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic [3:0] i_prev_value,
    output logic [3:0] o_random_out,
    output logic       o_capture,
    output logic       o_busy
);
    localparam int SW = $clog2(NUM_STEPS + 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);

    typedef enum logic [1:0] {IDLE, ROLL, DONE} state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [31:0]   cnt;
    logic [31:0]   period;
    logic [SW-1:0] step;
    logic          stop_pend;

    logic          fb;
    logic          upd;
    logic          fin;
    logic [3:0]    final_val;

    // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form
    assign fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    // A latched stop forces the next cycle to be the final update.
    assign upd = stop_pend || (cnt == period - 32'd1);
    assign fin = stop_pend || i_stop || (step == LAST_STEP);

    assign final_val = (AVOID_REPEAT && (lfsr[3:0] == i_prev_value)) ?
                       (lfsr[3:0] ^ 4'h1) : lfsr[3:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            o_random_out <= '0;
            o_capture    <= 1'b0;
            o_busy       <= 1'b0;
            lfsr         <= LFSR_SEED;
            cnt          <= '0;
            step         <= '0;
            period       <= 32'(INIT_PERIOD);
            stop_pend    <= 1'b0;
        end else begin
            lfsr <= {fb, lfsr[15:1]};
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state     <= ROLL;
                        cnt       <= '0;
                        step      <= '0;
                        period    <= 32'(INIT_PERIOD);
                        stop_pend <= 1'b0;
                        o_busy    <= 1'b1;
                    end
                end
                ROLL: begin
                    if (upd) begin
                        o_random_out <= fin ? final_val : lfsr[3:0];
                        cnt          <= '0;
                        step         <= step + SW'(1);
                        period       <= period + 32'(PERIOD_INC);
                        if (fin) begin
                            state     <= DONE;
                            o_capture <= 1'b1;
                            stop_pend <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                        if (i_stop) stop_pend <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    o_capture <= 1'b0;
                    o_busy    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rng_roll_controller.sv
// Bench for rng_roll_controller: directed roll scenarios plus random key traffic,
// checked every cycle against a schedule-based reference model.
module tb_rng_roll_controller;
    localparam int INIT = 4;
    localparam int INC  = 2;
    localparam int N    = 3;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_stop = 1'b0;
    logic [3:0] i_prev_value = 4'h0;
    logic [3:0] rnd1, rnd0;
    logic       cap1, cap0, busy1, busy0;

    int cmp = 0;
    int errs = 0;
    int cur = 0;
    bit chk_en = 1'b0;

    always #5 i_clk = ~i_clk;

    rng_roll_controller #(.LFSR_SEED(16'hACE1), .INIT_PERIOD(INIT), .PERIOD_INC(INC),
                          .NUM_STEPS(N), .AVOID_REPEAT(1'b1)) dut1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_prev_value(i_prev_value), .o_random_out(rnd1), .o_capture(cap1), .o_busy(busy1));

    rng_roll_controller #(.LFSR_SEED(16'hACE1), .INIT_PERIOD(INIT), .PERIOD_INC(INC),
                          .NUM_STEPS(N), .AVOID_REPEAT(1'b0)) dut0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_prev_value(i_prev_value), .o_random_out(rnd0), .o_capture(cap0), .o_busy(busy0));

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Roll cycle on which update k (1-based) falls: sum of the first k intervals.
    function automatic int due(input int k);
        return k * INIT + INC * k * (k - 1) / 2;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        cmp++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model
    logic [15:0] m_lfsr = 16'hACE1;
    logic        m_busy = 0, m_cap = 0, m_roll = 0, m_done = 0, m_stop = 0;
    logic [3:0]  m_rnd1 = 0, m_rnd0 = 0;
    int          m_age = 0, m_k = 0;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_lfsr <= 16'hACE1; m_busy <= 0; m_cap <= 0; m_roll <= 0; m_done <= 0;
            m_stop <= 0; m_rnd1 <= 0; m_rnd0 <= 0; m_age <= 0; m_k <= 0;
        end else begin
            automatic int  age = m_age + 1;
            automatic bit  update, last;
            automatic logic [3:0] v = m_lfsr[3:0];
            m_lfsr <= lfsr_next(m_lfsr);
            if (m_done) begin
                m_done <= 0; m_cap <= 0; m_busy <= 0;
            end else if (m_roll) begin
                m_age  <= age;
                update = m_stop || (age == due(m_k + 1));
                if (update) begin
                    last = m_stop || i_stop || (m_k + 1 == N);
                    m_k    <= m_k + 1;
                    m_rnd0 <= v;
                    m_rnd1 <= (last && v == i_prev_value) ? (v ^ 4'h1) : v;
                    if (last) begin
                        m_roll <= 0; m_done <= 1; m_cap <= 1; m_stop <= 0;
                    end
                end else if (i_stop) begin
                    m_stop <= 1;
                end
            end else if (i_start) begin
                m_roll <= 1; m_busy <= 1; m_age <= 0; m_k <= 0; m_stop <= 0;
            end
        end
    end

    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("busy1", 16'(busy1), 16'(m_busy));
            chk("busy0", 16'(busy0), 16'(m_busy));
            chk("cap1",  16'(cap1),  16'(m_cap));
            chk("cap0",  16'(cap0),  16'(m_cap));
            chk("rnd1",  16'(rnd1),  16'(m_rnd1));
            chk("rnd0",  16'(rnd0),  16'(m_rnd0));
        end
    end

    task automatic step_to(input int n);
        while (cur < n) begin
            @(negedge i_clk);
            cur++;
        end
    endtask

    // Drive start (optionally with stop) for one cycle; returns at ROLL cycle 1.
    task automatic go(input bit with_stop);
        i_start = 1'b1; i_stop = with_stop;
        @(negedge i_clk);
        i_start = 1'b0; i_stop = 1'b0;
        cur = 1;
    endtask

    task automatic check_normal_roll(input string tag);
        chk({tag, "_busy_c1"}, 16'(busy1), 16'd1);
        step_to(18);
        chk({tag, "_cap_c18"}, 16'(cap1), 16'd0);
        step_to(19);
        chk({tag, "_cap_c19"}, 16'(cap1), 16'd1);
        chk({tag, "_busy_c19"}, 16'(busy1), 16'd1);
        step_to(20);
        chk({tag, "_cap_c20"}, 16'(cap1), 16'd0);
        chk({tag, "_busy_c20"}, 16'(busy1), 16'd0);
    endtask

    initial begin
        logic [3:0] nib;
        // Pin the model's primitives with hand-computed values
        chk("lfsr_step1", lfsr_next(16'hACE1), 16'h5670);
        chk("lfsr_step2", lfsr_next(16'h5670), 16'hAB38);
        chk("due_1", 16'(due(1)), 16'd4);
        chk("due_2", 16'(due(2)), 16'd10);
        chk("due_3", 16'(due(3)), 16'd18);

        // Test 1: reset state and quiet idle
        repeat (3) @(negedge i_clk);
        chk_en = 1'b1;
        chk("rst_lfsr", dut1.lfsr, 16'hACE1);
        chk("rst_rnd", 16'(rnd1), 16'd0);
        chk("rst_busy", 16'(busy1), 16'd0);
        i_rst_n = 1'b1;
        repeat (100) @(negedge i_clk);
        chk("idle_rnd", 16'(rnd1), 16'd0);
        chk("idle_cap", 16'(cap1), 16'd0);

        // Test 2: normal roll timing
        go(1'b0);
        check_normal_roll("t2");

        // Test 3: stop on ROLL cycle 6
        repeat (3) @(negedge i_clk);
        go(1'b0);
        step_to(6);
        i_stop = 1'b1;
        step_to(7);
        i_stop = 1'b0;
        chk("t3_cap_c7", 16'(cap1), 16'd0);
        step_to(8);
        chk("t3_cap_c8", 16'(cap1), 16'd1);
        nib = rnd1;
        step_to(9);
        chk("t3_busy_c9", 16'(busy1), 16'd0);
        step_to(30);
        chk("t3_hold", 16'(rnd1), 16'(nib));

        // Test 4: avoid-repeat against the predicted final nibble
        go(1'b0);
        step_to(18);
        nib = m_lfsr[3:0];
        i_prev_value = nib;
        step_to(19);
        chk("t4_avoid1", 16'(rnd1), 16'(nib ^ 4'h1));
        chk("t4_avoid0", 16'(rnd0), 16'(nib));
        step_to(22);

        // Test 5: start+stop together in IDLE, extra starts in ROLL and DONE
        go(1'b1);
        step_to(3);  i_start = 1'b1;
        step_to(4);  i_start = 1'b0;
        step_to(10); i_start = 1'b1;
        step_to(11); i_start = 1'b0;
        step_to(19);
        chk("t5_cap_c19", 16'(cap1), 16'd1);
        i_start = 1'b1;
        step_to(20);
        i_start = 1'b0;
        chk("t5_busy_c20", 16'(busy1), 16'd0);
        step_to(21);
        chk("t5_busy_c21", 16'(busy1), 16'd0);

        // Test 6: async reset mid-roll, then a clean roll
        go(1'b0);
        step_to(12);
        i_rst_n = 1'b0;
        #1;
        chk("t6_async_busy", 16'(busy1), 16'd0);
        chk("t6_async_rnd", 16'(rnd1), 16'd0);
        chk("t6_async_cap", 16'(cap1), 16'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        go(1'b0);
        check_normal_roll("t6");

        // Random key traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge i_clk);
            i_start      = ($urandom_range(0, 29) == 0);
            i_stop       = ($urandom_range(0, 39) == 0);
            i_prev_value = 4'($urandom);
            i_rst_n      = ($urandom_range(0, 1499) != 0);
        end
        @(negedge i_clk);
        i_start = 1'b0; i_stop = 1'b0; i_rst_n = 1'b1;
        repeat (40) @(negedge i_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
